// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity mode constants and
// the bit-timer width helper, reused by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4,
      ST_BRK_WAIT = 3'd5
   } rx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Bits needed to hold counts 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchroniser for the serial line plus a 2-of-3 majority voter over
// the samples taken at counts MID-1, MID and MID+1 of the bit window.
module uart_bit_sampler #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_rx,
   input  logic [CNT_W-1:0] i_count,
   input  logic [CNT_W-1:0] i_mid,
   output logic             o_sync,
   output logic             o_vote
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic samp0_q, samp0_d;
   logic samp1_q, samp1_d;

   always_comb begin
      sync1_d = i_rx;
      sync2_d = sync1_q;
      samp0_d = samp0_q;
      samp1_d = samp1_q;
      if (i_count == (i_mid - CNT_W'(1))) samp0_d = sync2_q;
      if (i_count == i_mid)               samp1_d = sync2_q;
   end

   // Preset to the idle level so a reset never looks like a start bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         samp0_q <= samp0_d;
         samp1_q <= samp1_d;
      end
   end

   // Third sample is the live synchronised value at count MID+1.
   assign o_sync = sync2_q;
   assign o_vote = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-voted sampling, parity/framing/break flags and half-bit early resync.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int CNT_W = cnt_width(CLKS_PER_BIT);
   localparam int IDX_W = cnt_width(DATA_BITS);
   localparam int MID   = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(MID + 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             PAR_EN    = (PARITY_MODE != PARITY_NONE);
   localparam logic             PAR_ODD   = (PARITY_MODE == PARITY_ODD);
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     timer_q, timer_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pbit_q, pbit_d;
   logic                 par_pend_q, par_pend_d;
   logic                 frm_pend_q, frm_pend_d;
   logic                 stop_low_q, stop_low_d;
   logic                 rx_dv_q, rx_dv_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 break_q, break_d;
   logic                 busy_q, busy_d;

   logic rx_sync;
   logic vote;
   logic at_vote;
   logic at_end;
   logic brk_now;

   uart_bit_sampler #(
      .CNT_W (CNT_W)
   ) u_sampler (
      .i_clk   (i_Clock),
      .i_rst_n (i_Rst_n),
      .i_rx    (i_Rx_Serial),
      .i_count (timer_q),
      .i_mid   (CNT_MID),
      .o_sync  (rx_sync),
      .o_vote  (vote)
   );

   assign at_vote = (timer_q == CNT_VOTE);
   assign at_end  = (timer_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      timer_d      = at_end ? '0 : timer_q + CNT_W'(1);
      idx_d        = idx_q;
      stop_idx_d   = stop_idx_q;
      shift_d      = shift_q;
      pbit_d       = pbit_q;
      par_pend_d   = par_pend_q;
      frm_pend_d   = frm_pend_q;
      stop_low_d   = stop_low_q;
      rx_dv_d      = 1'b0;
      rx_byte_d    = rx_byte_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      break_d      = break_q;
      brk_now      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            timer_d    = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            if (!rx_sync) begin
               state_d    = ST_START;
               pbit_d     = 1'b0;
               par_pend_d = 1'b0;
               frm_pend_d = 1'b0;
               stop_low_d = 1'b1;
            end
         end

         ST_START: begin
            if (at_vote && vote) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (at_end) begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (at_vote) shift_d[idx_q] = vote;
            if (at_end) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = PAR_EN ? ST_PARITY : ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_PARITY: begin
            if (at_vote) begin
               pbit_d     = vote;
               par_pend_d = ((^shift_q) ^ vote) != PAR_ODD;
            end
            if (at_end) state_d = ST_STOP;
         end

         // The final stop vote completes the frame half a bit early so the
         // next start edge is never missed.
         ST_STOP: begin
            if (at_vote) begin
               if (!vote) frm_pend_d = 1'b1;
               else       stop_low_d = 1'b0;
               if (stop_idx_q == STOP_LAST) begin
                  brk_now      = (shift_q == '0) && !pbit_q && stop_low_q && !vote;
                  rx_dv_d      = 1'b1;
                  rx_byte_d    = shift_q;
                  parity_err_d = par_pend_q;
                  frame_err_d  = frm_pend_q | ~vote;
                  break_d      = brk_now;
                  timer_d      = '0;
                  state_d      = brk_now ? ST_BRK_WAIT : ST_IDLE;
               end
            end else if (at_end) begin
               stop_idx_d = 1'b1;
            end
         end

         ST_BRK_WAIT: begin
            timer_d = '0;
            if (rx_sync) state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         idx_q        <= '0;
         stop_idx_q   <= 1'b0;
         shift_q      <= '0;
         pbit_q       <= 1'b0;
         par_pend_q   <= 1'b0;
         frm_pend_q   <= 1'b0;
         stop_low_q   <= 1'b0;
         rx_dv_q      <= 1'b0;
         rx_byte_q    <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         idx_q        <= idx_d;
         stop_idx_q   <= stop_idx_d;
         shift_q      <= shift_d;
         pbit_q       <= pbit_d;
         par_pend_q   <= par_pend_d;
         frm_pend_q   <= frm_pend_d;
         stop_low_q   <= stop_low_d;
         rx_dv_q      <= rx_dv_d;
         rx_byte_q    <= rx_byte_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         break_q      <= break_d;
         busy_q       <= busy_d;
      end
   end

   assign o_Rx_DV      = rx_dv_q;
   assign o_Rx_Byte    = rx_byte_q;
   assign o_Parity_Err = parity_err_q;
   assign o_Frame_Err  = frame_err_q;
   assign o_Break      = break_q;
   assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: three receivers (8N1, 8E1, 7O2) driven by a
// reference serializer, results scored against hand-computed frame records.
module tb_uart_rx_ext;
   import uart_pkg::*;

   localparam int CPB = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- DUTs ----------------
   logic       rx_a, rx_b, rx_c;
   logic       dv_a, dv_b, dv_c;
   logic [7:0] byte_a, byte_b;
   logic [6:0] byte_c;
   logic       perr_a, perr_b, perr_c;
   logic       ferr_a, ferr_b, ferr_c;
   logic       brk_a, brk_b, brk_c;
   logic       busy_a, busy_b, busy_c;

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(1)) dut_8n1 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
      .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Busy(busy_a));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1)) dut_8e1 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
      .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Busy(busy_b));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(PARITY_ODD), .STOP_BITS(2)) dut_7o2 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
      .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Break(brk_c), .o_Busy(busy_c));

   // ---------------- scoreboard ----------------
   // Frame record: {busy, break, frame_err, parity_err, data[8:0]}
   logic [12:0] exp_q[$];
   logic [12:0] rx_qa[$], rx_qb[$], rx_qc[$];
   int n_checks = 0;
   int n_errors = 0;
   int dv_long = 0;
   int dv_cyc_a = 0;
   int fall_cyc = 0;
   logic dv_a_prev = 1'b0, dv_b_prev = 1'b0, dv_c_prev = 1'b0;

   initial forever begin
      @(negedge clk);
      if (dv_a) begin
         rx_qa.push_back({busy_a, brk_a, ferr_a, perr_a, 1'b0, byte_a});
         dv_cyc_a = cyc;
      end
      if (dv_b) rx_qb.push_back({busy_b, brk_b, ferr_b, perr_b, 1'b0, byte_b});
      if (dv_c) rx_qc.push_back({busy_c, brk_c, ferr_c, perr_c, 2'b00, byte_c});
      if ((dv_a && dv_a_prev) || (dv_b && dv_b_prev) || (dv_c && dv_c_prev)) dv_long++;
      dv_a_prev = dv_a;
      dv_b_prev = dv_b;
      dv_c_prev = dv_c;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int rx_size(input int sel);
      case (sel)
         0:       return rx_qa.size();
         1:       return rx_qb.size();
         default: return rx_qc.size();
      endcase
   endfunction

   function automatic logic [12:0] rx_pop(input int sel);
      case (sel)
         0:       return rx_qa.pop_front();
         1:       return rx_qb.pop_front();
         default: return rx_qc.pop_front();
      endcase
   endfunction

   // Match every queued expectation against received frames, then demand no extras.
   task automatic score(input int sel, input string tag);
      int n;
      logic [12:0] e, g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = 0;
         while (rx_size(sel) == 0 && n < 64) begin
            @(negedge clk);
            n++;
         end
         if (rx_size(sel) == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
         end else begin
            g = rx_pop(sel);
            check(tag, 32'(g), 32'(e));
         end
      end
      check({tag, "_extra"}, 32'(rx_size(sel)), 32'd0);
   endtask

   // ---------------- drivers ----------------
   task automatic set_line(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic drive_bit(input int sel, input logic v, input bit spike);
      for (int k = 0; k < CPB; k++) begin
         set_line(sel, (spike && k == 7) ? ~v : v);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                             input int pmode, input logic pflip, input logic [1:0] stops,
                             input int nstops, input int spike_bit);
      logic p;
      if (sel == 0) fall_cyc = cyc;
      drive_bit(sel, 1'b0, 1'b0);
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      if (pmode == PARITY_ODD) p = ~p;
      for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], i == spike_bit);
      if (pmode != PARITY_NONE) drive_bit(sel, p ^ pflip, 1'b0);
      for (int i = 0; i < nstops; i++) drive_bit(sel, stops[i], 1'b0);
      set_line(sel, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      rx_a = 1'b1;
      rx_b = 1'b1;
      rx_c = 1'b1;
      idle(3);
      check("rst_8n1", 32'({dv_a, busy_a, brk_a, ferr_a, perr_a, byte_a}), 32'd0);
      check("rst_8e1", 32'({dv_b, busy_b, brk_b, ferr_b, perr_b, byte_b}), 32'd0);
      check("rst_7o2", 32'({dv_c, busy_c, brk_c, ferr_c, perr_c, byte_c}), 32'd0);
      rst_n = 1'b1;
      idle(5);

      // 8N1 0xA5, with latency 2 + 9*16 + 7 + 2 = 155 clocks; edge 0 is the
      // first clock edge that sees the falling start edge.
      exp_q.push_back(13'h0A5);
      send_frame(0, 9'h0A5, 8, PARITY_NONE, 1'b0, 2'b11, 1, -1);
      idle(20);
      score(0, "a5");
      check("a5_latency", 32'(dv_cyc_a - fall_cyc - 1), 32'd155);
      check("a5_busy_idle", 32'(busy_a), 32'd0);

      // 8E1 0x3C: good parity, then flipped parity bit
      exp_q.push_back(13'h03C);
      exp_q.push_back(13'h23C);
      send_frame(1, 9'h03C, 8, PARITY_EVEN, 1'b0, 2'b11, 1, -1);
      idle(20);
      send_frame(1, 9'h03C, 8, PARITY_EVEN, 1'b1, 2'b11, 1, -1);
      idle(20);
      score(1, "e1_3c");

      // 7O2 0x55: clean frame, then second stop bit low
      exp_q.push_back(13'h055);
      exp_q.push_back(13'h455);
      send_frame(2, 9'h055, 7, PARITY_ODD, 1'b0, 2'b11, 2, -1);
      idle(20);
      send_frame(2, 9'h055, 7, PARITY_ODD, 1'b0, 2'b01, 2, -1);
      idle(40);
      score(2, "o2_55");

      // Break: line low for three frame times, one flagged frame only
      exp_q.push_back(13'h1C00);
      set_line(0, 1'b0);
      idle(3 * 10 * CPB);
      check("brk_busy_held", 32'(busy_a), 32'd1);
      score(0, "brk");
      set_line(0, 1'b1);
      idle(20);
      check("brk_busy_rel", 32'(busy_a), 32'd0);
      exp_q.push_back(13'h0A5);
      send_frame(0, 9'h0A5, 8, PARITY_NONE, 1'b0, 2'b11, 1, -1);
      idle(20);
      score(0, "post_brk");

      // Start glitch of 3 clocks, then a one-clock spike inside data bit 1
      set_line(0, 1'b0);
      idle(3);
      set_line(0, 1'b1);
      idle(40);
      check("glitch_busy", 32'(busy_a), 32'd0);
      score(0, "glitch");
      exp_q.push_back(13'h05A);
      send_frame(0, 9'h05A, 8, PARITY_NONE, 1'b0, 2'b11, 1, 1);
      idle(20);
      score(0, "spike");

      // Back-to-back frames with zero idle
      exp_q.push_back(13'h000);
      exp_q.push_back(13'h0FF);
      send_frame(0, 9'h000, 8, PARITY_NONE, 1'b0, 2'b11, 1, -1);
      send_frame(0, 9'h0FF, 8, PARITY_NONE, 1'b0, 2'b11, 1, -1);
      idle(20);
      score(0, "b2b");

      // Reset mid-frame: start + four data bits of 0xA5, then reset
      drive_bit(0, 1'b0, 1'b0);
      drive_bit(0, 1'b1, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      drive_bit(0, 1'b1, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      rst_n = 1'b0;
      set_line(0, 1'b1);
      idle(3);
      rst_n = 1'b1;
      idle(400);
      check("rst_mid_outs", 32'({dv_a, busy_a, brk_a, ferr_a, perr_a, byte_a}), 32'd0);
      score(0, "rst_mid");

      check("dv_width", 32'(dv_long), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
